// File: rtl/dispatch_stage_pkg.sv
// Shared core definitions for the dispatch/issue path: default widths and the
// dispatch-entry layout carried from the renamer into the issue queues.
package dispatch_stage_pkg;

  localparam int DEF_INST_ID_BITS = 6;
  localparam int DEF_PRN_BITS     = 6;
  localparam int DEF_MAX_OPERANDS = 3;
  localparam int DEF_FU_COUNT     = 4;
  localparam int DEF_FU_SEL_BITS  = (DEF_FU_COUNT > 1) ? $clog2(DEF_FU_COUNT) : 1;

  typedef struct packed {
    logic [DEF_INST_ID_BITS-1:0]                     inst_id;
    logic [31:0]                                     raw_instr;
    logic [63:0]                                     instr_pc;
    logic [DEF_FU_SEL_BITS-1:0]                      fu_sel;
    logic [DEF_MAX_OPERANDS-1:0]                     prn_input_valid;
    logic [DEF_MAX_OPERANDS-1:0][DEF_PRN_BITS-1:0]   prn_input;
    logic [DEF_MAX_OPERANDS-1:0]                     prn_output_valid;
    logic [DEF_MAX_OPERANDS-1:0][DEF_PRN_BITS-1:0]   prn_output;
  } dispatch_entry_t;

endpackage

// File: rtl/dispatch_stage_prn_scoreboard.sv
// Physical-register ready scoreboard: writeback strobes set bits, dispatched
// destinations clear them, and reads see same-cycle writebacks as ready.
module prn_scoreboard #(
  parameter int PRN_BITS     = 6,
  parameter int MAX_OPERANDS = 3,
  parameter int FU_COUNT     = 4
) (
  input  logic                                                  clk,
  input  logic                                                  rst,
  input  logic [FU_COUNT-1:0][MAX_OPERANDS-1:0]                 set_valid,
  input  logic [FU_COUNT-1:0][MAX_OPERANDS-1:0][PRN_BITS-1:0]   set_prn,
  input  logic [MAX_OPERANDS-1:0]                               clr_valid,
  input  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]                 clr_prn,
  input  logic [MAX_OPERANDS-1:0]                               rd_valid,
  input  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]                 rd_prn,
  output logic [MAX_OPERANDS-1:0]                               rd_ready
);

  localparam int PRN_COUNT = 2 ** PRN_BITS;

  logic [PRN_COUNT-1:0]    ready_r;
  logic [PRN_COUNT-1:0]    ready_nxt_s;
  logic [MAX_OPERANDS-1:0] bypass_s;

  // Next-state: sets first, then clears so a dispatching producer wins; PRN 0 pinned ready.
  always_comb begin
    ready_nxt_s = ready_r;
    for (int k = 0; k < FU_COUNT; k++) begin
      for (int j = 0; j < MAX_OPERANDS; j++) begin
        ready_nxt_s[set_prn[k][j]] = ready_nxt_s[set_prn[k][j]] | set_valid[k][j];
      end
    end
    for (int j = 0; j < MAX_OPERANDS; j++) begin
      ready_nxt_s[clr_prn[j]] = ready_nxt_s[clr_prn[j]] & ~clr_valid[j];
    end
    ready_nxt_s[0] = 1'b1;
  end

  // Scoreboard state register; everything is ready out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ready_r <= '1;
    end else begin
      ready_r <= ready_nxt_s;
    end
  end

  // Read ports with writeback bypass.
  always_comb begin
    bypass_s = '0;
    rd_ready = '0;
    for (int j = 0; j < MAX_OPERANDS; j++) begin
      for (int k = 0; k < FU_COUNT; k++) begin
        for (int i = 0; i < MAX_OPERANDS; i++) begin
          bypass_s[j] = bypass_s[j] | (set_valid[k][i] & (set_prn[k][i] == rd_prn[j]));
        end
      end
      rd_ready[j] = ~rd_valid[j] | ready_r[rd_prn[j]] | bypass_s[j];
    end
  end

endmodule

// File: rtl/dispatch_stage.sv
// In-order dispatch buffer between rename and the issue queues; routes the head
// entry to its issue queue and reports source readiness from the PRN scoreboard.
module dispatch_stage
  import dispatch_stage_pkg::*;
#(
  parameter int INST_ID_BITS = DEF_INST_ID_BITS,
  parameter int PRN_BITS     = DEF_PRN_BITS,
  parameter int MAX_OPERANDS = DEF_MAX_OPERANDS,
  parameter int FU_COUNT     = DEF_FU_COUNT,
  parameter int FIFO_DEPTH   = 4,
  localparam int FU_SEL_BITS = (FU_COUNT > 1) ? $clog2(FU_COUNT) : 1
) (
  input  logic                                                  clk,
  input  logic                                                  rst,
  input  logic                                                  in_valid,
  output logic                                                  in_ready,
  input  logic [INST_ID_BITS-1:0]                               inst_id,
  input  logic [31:0]                                           raw_instr,
  input  logic [63:0]                                           instr_pc,
  input  logic [FU_SEL_BITS-1:0]                                fu_sel,
  input  logic [MAX_OPERANDS-1:0]                               prn_input_valid,
  input  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]                 prn_input,
  input  logic [MAX_OPERANDS-1:0]                               prn_output_valid,
  input  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]                 prn_output,
  input  logic [FU_COUNT-1:0][MAX_OPERANDS-1:0]                 set_prn_ready,
  input  logic [FU_COUNT-1:0][MAX_OPERANDS-1:0][PRN_BITS-1:0]   set_prn,
  input  logic                                                  flush,
  input  logic [FU_COUNT-1:0]                                   iq_queue_ready,
  output logic [FU_COUNT-1:0]                                   iq_inst_valid,
  output logic [INST_ID_BITS-1:0]                               iq_inst_id,
  output logic [31:0]                                           iq_raw_instr,
  output logic [63:0]                                           iq_instr_pc,
  output logic [MAX_OPERANDS-1:0]                               iq_prn_input_valid,
  output logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]                 iq_prn_input,
  output logic [MAX_OPERANDS-1:0]                               iq_prn_output_valid,
  output logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]                 iq_prn_output,
  output logic [MAX_OPERANDS-1:0]                               iq_prn_input_ready
);

  localparam int PTR_BITS = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_BITS:0] FULL_COUNT = (PTR_BITS + 1)'(FIFO_DEPTH);

  dispatch_entry_t               mem_r [FIFO_DEPTH];
  logic [PTR_BITS-1:0]           wr_ptr_r;
  logic [PTR_BITS-1:0]           rd_ptr_r;
  logic [PTR_BITS:0]             count_r;
  dispatch_entry_t               head_s;
  dispatch_entry_t               in_entry_s;
  logic                          full_s;
  logic                          empty_s;
  logic                          enq_s;
  logic                          deq_s;
  logic [MAX_OPERANDS-1:0]       clr_valid_s;

  assign full_s   = (count_r == FULL_COUNT);
  assign empty_s  = (count_r == {(PTR_BITS + 1){1'b0}});
  assign in_ready = ~rst & ~full_s;
  assign enq_s    = in_valid & in_ready & ~flush;
  assign deq_s    = |iq_inst_valid;
  assign head_s   = mem_r[rd_ptr_r];

  // Pack the renamer's offer into a buffer entry.
  always_comb begin
    in_entry_s                  = '0;
    in_entry_s.inst_id          = inst_id;
    in_entry_s.raw_instr        = raw_instr;
    in_entry_s.instr_pc         = instr_pc;
    in_entry_s.fu_sel           = fu_sel;
    in_entry_s.prn_input_valid  = prn_input_valid;
    in_entry_s.prn_input        = prn_input;
    in_entry_s.prn_output_valid = prn_output_valid;
    in_entry_s.prn_output       = prn_output;
  end

  // One-hot dispatch strobe: only the head, only to its own queue, never while flushing.
  always_comb begin
    iq_inst_valid = '0;
    for (int k = 0; k < FU_COUNT; k++) begin
      if (~rst && ~empty_s && ~flush && iq_queue_ready[k] &&
          (head_s.fu_sel == FU_SEL_BITS'(k))) begin
        iq_inst_valid[k] = 1'b1;
      end else begin
        iq_inst_valid[k] = 1'b0;
      end
    end
  end

  // Head payload straight from storage.
  always_comb begin
    iq_inst_id          = head_s.inst_id;
    iq_raw_instr        = head_s.raw_instr;
    iq_instr_pc         = head_s.instr_pc;
    iq_prn_input_valid  = head_s.prn_input_valid;
    iq_prn_input        = head_s.prn_input;
    iq_prn_output_valid = head_s.prn_output_valid;
    iq_prn_output       = head_s.prn_output;
    clr_valid_s         = head_s.prn_output_valid & {MAX_OPERANDS{deq_s}};
  end

  // Pointer and occupancy bookkeeping; flush and reset both empty the buffer.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (enq_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_BITS'(1);
      end
      if (deq_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_BITS'(1);
      end
      case ({enq_s, deq_s})
        2'b10:   count_r <= count_r + (PTR_BITS + 1)'(1);
        2'b01:   count_r <= count_r - (PTR_BITS + 1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; enq_s already excludes reset and flush.
  always_ff @(posedge clk) begin
    if (enq_s) begin
      mem_r[wr_ptr_r] <= in_entry_s;
    end
  end

  prn_scoreboard #(
    .PRN_BITS     (PRN_BITS),
    .MAX_OPERANDS (MAX_OPERANDS),
    .FU_COUNT     (FU_COUNT)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .set_valid (set_prn_ready),
    .set_prn   (set_prn),
    .clr_valid (clr_valid_s),
    .clr_prn   (head_s.prn_output),
    .rd_valid  (head_s.prn_input_valid),
    .rd_prn    (head_s.prn_input),
    .rd_ready  (iq_prn_input_ready)
  );

endmodule

// File: tb/tb_dispatch_stage.sv
// Directed bench for dispatch_stage: stimulus queues expected dispatches, a
// negedge monitor pops and compares every dispatch the DUT presents.
module tb_dispatch_stage;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    in_valid = 1'b0;
  logic                    in_ready;
  logic [5:0]              inst_id = 6'd0;
  logic [31:0]             raw_instr = 32'd0;
  logic [63:0]             instr_pc = 64'd0;
  logic [1:0]              fu_sel = 2'd0;
  logic [2:0]              prn_input_valid = 3'd0;
  logic [2:0][5:0]         prn_input = '0;
  logic [2:0]              prn_output_valid = 3'd0;
  logic [2:0][5:0]         prn_output = '0;
  logic [3:0][2:0]         set_prn_ready = '0;
  logic [3:0][2:0][5:0]    set_prn = '0;
  logic                    flush = 1'b0;
  logic [3:0]              iq_queue_ready = 4'd0;
  logic [3:0]              iq_inst_valid;
  logic [5:0]              iq_inst_id;
  logic [31:0]             iq_raw_instr;
  logic [63:0]             iq_instr_pc;
  logic [2:0]              iq_prn_input_valid;
  logic [2:0][5:0]         iq_prn_input;
  logic [2:0]              iq_prn_output_valid;
  logic [2:0][5:0]         iq_prn_output;
  logic [2:0]              iq_prn_input_ready;

  typedef struct {
    logic [5:0] id;
    logic [1:0] fu;
    logic [2:0] rdy;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  dispatch_stage dut (
    .clk                 (clk),
    .rst                 (rst),
    .in_valid            (in_valid),
    .in_ready            (in_ready),
    .inst_id             (inst_id),
    .raw_instr           (raw_instr),
    .instr_pc            (instr_pc),
    .fu_sel              (fu_sel),
    .prn_input_valid     (prn_input_valid),
    .prn_input           (prn_input),
    .prn_output_valid    (prn_output_valid),
    .prn_output          (prn_output),
    .set_prn_ready       (set_prn_ready),
    .set_prn             (set_prn),
    .flush               (flush),
    .iq_queue_ready      (iq_queue_ready),
    .iq_inst_valid       (iq_inst_valid),
    .iq_inst_id          (iq_inst_id),
    .iq_raw_instr        (iq_raw_instr),
    .iq_instr_pc         (iq_instr_pc),
    .iq_prn_input_valid  (iq_prn_input_valid),
    .iq_prn_input        (iq_prn_input),
    .iq_prn_output_valid (iq_prn_output_valid),
    .iq_prn_output       (iq_prn_output),
    .iq_prn_input_ready  (iq_prn_input_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fields(input logic [5:0] id, input logic [1:0] fu,
                            input logic [2:0] siv, input logic [2:0][5:0] sp,
                            input logic [2:0] dov, input logic [2:0][5:0] dp);
    inst_id          = id;
    fu_sel           = fu;
    raw_instr        = 32'hA000_0000 | {26'd0, id};
    instr_pc         = 64'h1000 + ({58'd0, id} << 2);
    prn_input_valid  = siv;
    prn_input        = sp;
    prn_output_valid = dov;
    prn_output       = dp;
  endtask

  // Offer one instruction for one cycle; optionally record its expected dispatch.
  task automatic enq(input logic [5:0] id, input logic [1:0] fu,
                     input logic [2:0] siv, input logic [2:0][5:0] sp,
                     input logic [2:0] dov, input logic [2:0][5:0] dp,
                     input bit push, input logic [2:0] rdy);
    exp_t e;
    set_fields(id, fu, siv, sp, dov, dp);
    in_valid = 1'b1;
    if (push) begin
      e.id = id; e.fu = fu; e.rdy = rdy;
      exp_q.push_back(e);
    end
    cyc();
    in_valid = 1'b0;
  endtask

  // Monitor: every presented dispatch must match the oldest expectation.
  always @(negedge clk) begin
    if (iq_inst_valid != 4'd0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_dispatch", {58'd0, iq_inst_id}, 64'd0);
        check("unexpected_valid", {60'd0, iq_inst_valid}, 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("disp_id", {58'd0, iq_inst_id}, {58'd0, e.id});
        check("disp_onehot", {60'd0, iq_inst_valid}, 64'd1 << e.fu);
        check("disp_pc", iq_instr_pc, 64'h1000 + ({58'd0, e.id} << 2));
        check("disp_raw", {32'd0, iq_raw_instr}, {32'd0, 32'hA000_0000 | {26'd0, e.id}});
        check("disp_src_ready", {61'd0, iq_prn_input_ready}, {61'd0, e.rdy});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wait_n;
    // Reset behaviour
    cyc(); cyc();
    @(negedge clk);
    check("rst_in_ready", {63'd0, in_ready}, 64'd0);
    check("rst_iq_valid", {60'd0, iq_inst_valid}, 64'd0);
    cyc();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("post_rst_iq_valid", {60'd0, iq_inst_valid}, 64'd0);

    // Single instruction to queue 2, no bypass through an empty FIFO
    cyc();
    iq_queue_ready = 4'b1111;
    set_fields(6'd5, 2'd2, 3'b000, '0, 3'b000, '0);
    in_valid = 1'b1;
    exp_q.push_back('{id: 6'd5, fu: 2'd2, rdy: 3'b111});
    @(negedge clk);
    check("no_bypass", {60'd0, iq_inst_valid}, 64'd0);
    cyc();
    in_valid = 1'b0;
    @(negedge clk);
    check("single_valid", {60'd0, iq_inst_valid}, 64'h4);
    cyc();
    @(negedge clk);
    check("single_then_empty", {60'd0, iq_inst_valid}, 64'd0);

    // Fill to full with queues blocked, fifth held, then in-order drain
    cyc();
    iq_queue_ready = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      enq(6'(10 + i), 2'(i), 3'b000, '0, 3'b000, '0, 1'b1, 3'b111);
    end
    set_fields(6'd14, 2'd0, 3'b000, '0, 3'b000, '0);
    in_valid = 1'b1;
    @(negedge clk);
    check("full_in_ready", {63'd0, in_ready}, 64'd0);
    cyc();
    @(negedge clk);
    check("full_held_in_ready", {63'd0, in_ready}, 64'd0);
    check("full_blocked_valid", {60'd0, iq_inst_valid}, 64'd0);
    cyc();
    iq_queue_ready = 4'b1111;
    @(negedge clk);
    check("full_ready_ignores_deq", {63'd0, in_ready}, 64'd0);
    cyc();
    wait_n = 0;
    while (!in_ready && wait_n < 20) begin
      cyc();
      wait_n++;
    end
    check("fifth_accept_bound", {63'd0, in_ready}, 64'd1);
    exp_q.push_back('{id: 6'd14, fu: 2'd0, rdy: 3'b111});
    cyc();
    in_valid = 1'b0;
    repeat (6) cyc();
    check("drain_all", 64'(exp_q.size()), 64'd0);

    // Producer clears PRN 9; consumer sees it not ready, then ready via bypass
    enq(6'd20, 2'd0, 3'b000, '0, 3'b001, {6'd0, 6'd0, 6'd9}, 1'b1, 3'b111);
    cyc(); cyc();
    enq(6'd21, 2'd0, 3'b001, {6'd0, 6'd0, 6'd9}, 3'b000, '0, 1'b1, 3'b110);
    cyc(); cyc();
    enq(6'd22, 2'd0, 3'b001, {6'd0, 6'd0, 6'd9}, 3'b000, '0, 1'b1, 3'b111);
    set_prn_ready[1][0] = 1'b1;
    set_prn[1][0] = 6'd9;
    cyc();
    set_prn_ready = '0;
    set_prn = '0;
    cyc();

    // Clear beats same-cycle set; PRN 0 never cleared
    enq(6'd23, 2'd1, 3'b000, '0, 3'b001, {6'd0, 6'd0, 6'd9}, 1'b1, 3'b111);
    set_prn_ready[2][1] = 1'b1;
    set_prn[2][1] = 6'd9;
    cyc();
    set_prn_ready = '0;
    set_prn = '0;
    cyc();
    enq(6'd24, 2'd3, 3'b001, {6'd0, 6'd0, 6'd9}, 3'b000, '0, 1'b1, 3'b110);
    cyc();
    enq(6'd25, 2'd0, 3'b000, '0, 3'b010, {6'd0, 6'd0, 6'd0}, 1'b1, 3'b111);
    cyc();
    enq(6'd26, 2'd2, 3'b100, {6'd0, 6'd0, 6'd0}, 3'b000, '0, 1'b1, 3'b111);
    repeat (3) cyc();
    check("prn_tests_done", 64'(exp_q.size()), 64'd0);

    // Head blocked on busy queue 1 stalls a younger entry for queue 0
    iq_queue_ready = 4'b1101;
    enq(6'd30, 2'd1, 3'b000, '0, 3'b000, '0, 1'b1, 3'b111);
    enq(6'd31, 2'd0, 3'b000, '0, 3'b000, '0, 1'b1, 3'b111);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("inorder_stall", {60'd0, iq_inst_valid}, 64'd0);
      cyc();
    end
    iq_queue_ready = 4'b1111;
    repeat (3) cyc();
    check("stall_drained", 64'(exp_q.size()), 64'd0);

    // Flush with three buffered and a same-cycle offer
    iq_queue_ready = 4'b0000;
    enq(6'd40, 2'd0, 3'b000, '0, 3'b000, '0, 1'b0, 3'b111);
    enq(6'd41, 2'd1, 3'b000, '0, 3'b000, '0, 1'b0, 3'b111);
    enq(6'd42, 2'd2, 3'b000, '0, 3'b000, '0, 1'b0, 3'b111);
    set_fields(6'd43, 2'd0, 3'b000, '0, 3'b000, '0);
    in_valid = 1'b1;
    flush = 1'b1;
    iq_queue_ready = 4'b1111;
    @(negedge clk);
    check("flush_suppress", {60'd0, iq_inst_valid}, 64'd0);
    cyc();
    in_valid = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    check("flush_empty", {60'd0, iq_inst_valid}, 64'd0);
    check("flush_in_ready", {63'd0, in_ready}, 64'd1);
    cyc();
    @(negedge clk);
    check("flush_dropped_new", {60'd0, iq_inst_valid}, 64'd0);
    cyc();

    // Reset mid-operation drops entries and restores the scoreboard
    iq_queue_ready = 4'b0000;
    enq(6'd50, 2'd0, 3'b000, '0, 3'b000, '0, 1'b0, 3'b111);
    enq(6'd51, 2'd1, 3'b000, '0, 3'b000, '0, 1'b0, 3'b111);
    rst = 1'b1;
    iq_queue_ready = 4'b1111;
    @(negedge clk);
    check("midrst_in_ready", {63'd0, in_ready}, 64'd0);
    check("midrst_iq_valid", {60'd0, iq_inst_valid}, 64'd0);
    cyc();
    rst = 1'b0;
    @(negedge clk);
    check("midrst_dropped", {60'd0, iq_inst_valid}, 64'd0);
    check("midrst_in_ready_after", {63'd0, in_ready}, 64'd1);
    cyc();
    enq(6'd52, 2'd3, 3'b001, {6'd0, 6'd0, 6'd9}, 3'b000, '0, 1'b1, 3'b111);
    repeat (3) cyc();

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
